// File: rtl/vga_plot_scheduler_pkg.sv
// Shared definitions for the VGA plot scheduler: phase indices, screen bounds,
// the scheduler state encoding and the "next enabled phase" search helper.
package vga_plot_scheduler_pkg;

    localparam int PHASE_BACKGROUND   = 0;
    localparam int PHASE_NOTEBLOCKS   = 1;
    localparam int PHASE_OVERLAY      = 2;
    localparam int SCREEN_MAX_X       = 159;
    localparam int SCREEN_MAX_Y       = 119;
    localparam int SCREEN_COLOUR_BITS = 24;
    localparam int MAX_PHASES         = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_DONE  = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } phase_sel_t;

    // Lowest enabled phase index that is >= from.
    function automatic phase_sel_t first_enabled_from(input logic [MAX_PHASES-1:0] en,
                                                      input int from);
        phase_sel_t sel;
        sel = '0;
        for (int i = MAX_PHASES - 1; i >= 0; i--) begin
            if (en[i] && (i >= from)) begin
                sel.found = 1'b1;
                sel.idx   = 2'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/vga_plot_scheduler_watchdog.sv
// Idle-cycle watchdog for one scheduler phase: counts enabled cycles and pulses
// tc_o on the TIMEOUT_CYCLES-th consecutive one. TIMEOUT_CYCLES = 0 disables it.
module plot_phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign tc_o = 1'b0;
        end else begin : g_enabled
            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            assign tc_o = enable_i && (count_q == TC_VAL);

            always_comb begin
                count_d = count_q;
                if (clear_i || tc_o) begin
                    count_d = '0;
                end else if (enable_i) begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/vga_plot_scheduler.sv
// Shares the single vga_adapter pixel-write port between the per-frame draw
// sources, granting them one at a time in fixed phase order on each frame_start.
module vga_plot_scheduler
    import vga_plot_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int COORD_BITS     = 8,
    parameter int COLOUR_BITS    = SCREEN_COLOUR_BITS,
    parameter int MAX_X          = SCREEN_MAX_X,
    parameter int MAX_Y          = SCREEN_MAX_Y,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic                           frame_start,
    input  logic [NUM_REQ-1:0]             phase_enable,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*COORD_BITS-1:0]  req_x,
    input  logic [NUM_REQ*COORD_BITS-1:0]  req_y,
    input  logic [NUM_REQ*COLOUR_BITS-1:0] req_colour,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           plot,
    output logic [COORD_BITS-1:0]          x,
    output logic [COORD_BITS-1:0]          y,
    output logic [COLOUR_BITS-1:0]         colour,
    output logic                           busy,
    output logic [1:0]                     active_phase,
    output logic                           frame_done,
    output logic [15:0]                    pixel_count,
    output logic                           overrun,
    output logic                           timeout
);

    localparam logic [COORD_BITS-1:0] MAX_X_C = COORD_BITS'(MAX_X);
    localparam logic [COORD_BITS-1:0] MAX_Y_C = COORD_BITS'(MAX_Y);

    sched_state_e             state_q, state_d;
    logic [NUM_REQ-1:0]       en_q, en_d;
    logic [1:0]               phase_q, phase_d;
    logic                     plot_q, plot_d;
    logic [COORD_BITS-1:0]    x_q, x_d;
    logic [COORD_BITS-1:0]    y_q, y_d;
    logic [COLOUR_BITS-1:0]   colour_q, colour_d;
    logic [15:0]              count_q, count_d;
    logic                     overrun_q, overrun_d;
    logic                     timeout_q, timeout_d;

    logic                     in_phase;
    logic                     xfer;
    logic                     in_bounds;
    logic                     advance;
    logic                     wd_tc;
    phase_sel_t               sel;
    logic [COORD_BITS-1:0]    cur_x;
    logic [COORD_BITS-1:0]    cur_y;
    logic [COLOUR_BITS-1:0]   cur_colour;

    assign in_phase   = (state_q == ST_PHASE);
    assign cur_x      = req_x[int'(phase_q)*COORD_BITS +: COORD_BITS];
    assign cur_y      = req_y[int'(phase_q)*COORD_BITS +: COORD_BITS];
    assign cur_colour = req_colour[int'(phase_q)*COLOUR_BITS +: COLOUR_BITS];
    assign xfer       = in_phase && req_valid[phase_q];
    assign in_bounds  = (cur_x <= MAX_X_C) && (cur_y <= MAX_Y_C);

    plot_phase_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (CLOCK_50),
        .rst_i    (resetn),
        .clear_i  (~in_phase | xfer),
        .enable_i (in_phase & ~xfer),
        .tc_o     (wd_tc)
    );

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        phase_d   = phase_q;
        plot_d    = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        advance   = 1'b0;
        sel       = '0;

        // A frame_start in PHASE or DONE (including the DONE->IDLE cycle) is dropped.
        if (frame_start && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    en_d      = phase_enable;
                    count_d   = '0;
                    overrun_d = 1'b0;
                    timeout_d = 1'b0;
                    sel       = first_enabled_from(MAX_PHASES'(phase_enable), 0);
                    if (sel.found) begin
                        state_d = ST_PHASE;
                        phase_d = sel.idx;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PHASE: begin
                if (xfer) begin
                    x_d      = cur_x;
                    y_d      = cur_y;
                    colour_d = cur_colour;
                    // Off-screen pixels are consumed but never written or counted.
                    if (in_bounds) begin
                        plot_d = 1'b1;
                        if (count_q != 16'hFFFF) begin
                            count_d = count_q + 16'd1;
                        end
                    end
                    advance = req_last[phase_q];
                end
                if (wd_tc) begin
                    timeout_d = 1'b1;
                    advance   = 1'b1;
                end
                if (advance) begin
                    sel = first_enabled_from(MAX_PHASES'(en_q), int'(phase_q) + 1);
                    if (sel.found) begin
                        phase_d = sel.idx;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge resetn) begin
        if (resetn) begin
            state_q   <= ST_IDLE;
            en_q      <= '0;
            phase_q   <= '0;
            plot_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            phase_q   <= phase_d;
            plot_q    <= plot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    // Grant is decoded straight from the state register so reset drops it at once.
    assign req_ready    = in_phase ? (NUM_REQ'(1) << phase_q) : '0;
    assign busy         = (state_q != ST_IDLE);
    assign frame_done   = (state_q == ST_DONE);
    assign active_phase = phase_q;
    assign plot         = plot_q;
    assign x            = x_q;
    assign y            = y_q;
    assign colour       = colour_q;
    assign pixel_count  = count_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Randomised bench for vga_plot_scheduler with an in-bench frame-level model
// plus directed frames whose results are pinned with hand-computed values.
module tb_vga_plot_scheduler;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [2:0]  phase_enable;
    logic [2:0]  req_valid;
    logic [23:0] req_x;
    logic [23:0] req_y;
    logic [71:0] req_colour;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic        plot;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] colour;
    logic        busy;
    logic [1:0]  active_phase;
    logic        frame_done;
    logic [15:0] pixel_count;
    logic        overrun;
    logic        timeout;

    vga_plot_scheduler #(
        .NUM_REQ(3), .COORD_BITS(8), .COLOUR_BITS(24),
        .MAX_X(159), .MAX_Y(119), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLOCK_50(clk), .resetn(rst), .frame_start(frame_start),
        .phase_enable(phase_enable), .req_valid(req_valid), .req_x(req_x),
        .req_y(req_y), .req_colour(req_colour), .req_last(req_last),
        .req_ready(req_ready), .plot(plot), .x(x), .y(y), .colour(colour),
        .busy(busy), .active_phase(active_phase), .frame_done(frame_done),
        .pixel_count(pixel_count), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Requester pixel lists
    logic [7:0]  px [3][16];
    logic [7:0]  py [3][16];
    logic [23:0] pc [3][16];
    int          n_pix [3];
    int          ptr [3];
    bit          hold_v [3];
    int          vprob;
    logic [2:0]  cur_pe;

    // Model: 0 idle, 1 granting phase m_k, 2 done
    int          m_state, m_k, m_idle, m_cnt;
    logic [2:0]  m_en;
    bit          m_plot, m_ovr, m_to;
    logic [7:0]  m_x, m_y;
    logic [23:0] m_c;

    // Observed DUT activity for the directed checks
    int          done_seen, r1_seen, plots_seen, ph1_cycles;
    bit          saw_ph2;
    logic [7:0]  last_px, last_py;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_en(input logic [2:0] en, input int from);
        for (int i = from; i < 3; i++) if (en[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_k = 0; m_idle = 0; m_cnt = 0; m_en = '0;
        m_plot = 0; m_ovr = 0; m_to = 0; m_x = '0; m_y = '0; m_c = '0;
    endtask

    task automatic clear_stats();
        done_seen = 0; r1_seen = 0; plots_seen = 0; ph1_cycles = 0; saw_ph2 = 0;
        last_px = '0; last_py = '0;
    endtask

    task automatic drive(input bit fs);
        frame_start  = fs;
        phase_enable = cur_pe;
        for (int i = 0; i < 3; i++) begin
            bit has;
            has = ptr[i] < n_pix[i];
            req_valid[i] = hold_v[i] | (has && ($urandom_range(99) < vprob));
            req_x[i*8 +: 8]       = has ? px[i][ptr[i]] : 8'd0;
            req_y[i*8 +: 8]       = has ? py[i][ptr[i]] : 8'd0;
            req_colour[i*24 +: 24] = has ? pc[i][ptr[i]] : 24'd0;
            req_last[i]           = has && (ptr[i] == n_pix[i] - 1);
        end
    endtask

    task automatic compare();
        logic [2:0] er;
        er = (m_state == 1) ? 3'(1 << m_k) : 3'b000;
        chk("req_ready", req_ready, er);
        chk("busy", busy, m_state != 0);
        chk("frame_done", frame_done, m_state == 2);
        chk("plot", plot, m_plot);
        chk("pixel_count", pixel_count, m_cnt);
        chk("overrun", overrun, m_ovr);
        chk("timeout", timeout, m_to);
        if (m_state == 1) chk("active_phase", active_phase, m_k);
        if (m_plot) begin
            chk("x", x, m_x);
            chk("y", y, m_y);
            chk("colour", colour, m_c);
        end
        if (frame_done) done_seen++;
        if (req_ready[1]) r1_seen++;
        if (req_ready[1] && busy && active_phase == 2'd1) ph1_cycles++;
        if (req_ready[2]) saw_ph2 = 1;
        if (plot) begin plots_seen++; last_px = x; last_py = y; end
    endtask

    task automatic model_update(input bit fs);
        bit adv;
        int j;
        logic [7:0] vx, vy;
        case (m_state)
            0: begin
                m_plot = 0;
                if (fs) begin
                    m_en = phase_enable; m_cnt = 0; m_ovr = 0; m_to = 0;
                    j = next_en(m_en, 0);
                    if (j >= 0) begin m_state = 1; m_k = j; m_idle = 0; end
                    else m_state = 2;
                end
            end
            1: begin
                if (fs) m_ovr = 1;
                adv = 0;
                if (req_valid[m_k]) begin
                    vx = req_x[m_k*8 +: 8];
                    vy = req_y[m_k*8 +: 8];
                    m_plot = (vx <= 8'd159) && (vy <= 8'd119);
                    if (m_plot) begin
                        m_x = vx; m_y = vy; m_c = req_colour[m_k*24 +: 24];
                        if (m_cnt < 65535) m_cnt++;
                    end
                    adv = req_last[m_k];
                    if (ptr[m_k] < n_pix[m_k]) ptr[m_k]++;
                    m_idle = 0;
                end else begin
                    m_plot = 0;
                    m_idle++;
                    if (TO != 0 && m_idle == TO) begin m_to = 1; adv = 1; end
                end
                if (adv) begin
                    m_idle = 0;
                    j = next_en(m_en, m_k + 1);
                    if (j >= 0) m_k = j;
                    else m_state = 2;
                end
            end
            default: begin
                if (fs) m_ovr = 1;
                m_plot = 0;
                m_state = 0;
            end
        endcase
    endtask

    task automatic step(input bit fs);
        drive(fs);
        @(negedge clk);
        compare();
        model_update(fs);
        @(posedge clk);
        #1;
    endtask

    task automatic setup_req(input int i, input int n, input bit wide);
        n_pix[i] = n; ptr[i] = 0; hold_v[i] = 0;
        for (int k = 0; k < 16; k++) begin
            px[i][k] = wide ? 8'($urandom_range(170)) : 8'($urandom_range(159));
            py[i][k] = wide ? 8'($urandom_range(125)) : 8'($urandom_range(119));
            pc[i][k] = 24'($urandom);
        end
    endtask

    task automatic run_frame(input logic [2:0] pe, input int fs_prob, input int ovr_ph);
        int  cyc;
        bit  fs, ovr_done;
        cur_pe = pe;
        clear_stats();
        step(1'b1);
        cyc = 0; ovr_done = 0;
        while (m_state != 0 && cyc < 600) begin
            fs = ($urandom_range(999) < fs_prob);
            if (!ovr_done && m_state == 1 && m_k == ovr_ph) begin fs = 1; ovr_done = 1; end
            step(fs);
            cyc++;
        end
        step(1'b0);
        chk("frame_terminated", busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; frame_start = 0; phase_enable = 0; req_valid = 0;
        req_x = 0; req_y = 0; req_colour = 0; req_last = 0;
        cur_pe = 0; vprob = 100;
        for (int i = 0; i < 3; i++) begin n_pix[i] = 0; ptr[i] = 0; hold_v[i] = 0; end
        model_reset();
        clear_stats();
        #2;
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready", req_ready, 3'b000);
        chk("reset_plot", plot, 1'b0);
        chk("reset_count", pixel_count, 16'd0);
        chk("reset_flags", {overrun, timeout, frame_done, active_phase}, 5'd0);
        chk("reset_xyc", {x, y, colour}, 40'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0);

        // Basic sequencing: three phases, two pixels each
        vprob = 100;
        for (int i = 0; i < 3; i++) setup_req(i, 2, 0);
        run_frame(3'b111, 0, -1);
        chk("basic_count", pixel_count, 16'd6);
        chk("basic_model_count", m_cnt, 6);
        chk("basic_plots", plots_seen, 6);
        chk("basic_done_pulses", done_seen, 1);

        // Skipped phase with requester 1 holding valid
        for (int i = 0; i < 3; i++) setup_req(i, 2, 0);
        hold_v[1] = 1;
        run_frame(3'b101, 0, -1);
        hold_v[1] = 0;
        chk("skip_ready1", r1_seen, 0);
        chk("skip_count", pixel_count, 16'd4);
        chk("skip_saw_ph2", saw_ph2, 1'b1);

        // Clipping
        setup_req(0, 2, 0); setup_req(1, 0, 0); setup_req(2, 0, 0);
        px[0][0] = 8'd160; py[0][0] = 8'd10;
        px[0][1] = 8'd159; py[0][1] = 8'd119;
        run_frame(3'b001, 0, -1);
        chk("clip_count", pixel_count, 16'd1);
        chk("clip_plots", plots_seen, 1);
        chk("clip_x", last_px, 8'd159);
        chk("clip_y", last_py, 8'd119);

        // Overrun during phase 1, then cleared by the next accepted frame
        vprob = 50;
        for (int i = 0; i < 3; i++) setup_req(i, 2, 0);
        run_frame(3'b111, 0, 1);
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_count", pixel_count, 16'd6);
        vprob = 100;
        for (int i = 0; i < 3; i++) setup_req(i, 1, 0);
        run_frame(3'b111, 0, -1);
        chk("ovr_cleared", overrun, 1'b0);

        // Watchdog: requester 1 never offers a pixel
        setup_req(0, 1, 0); setup_req(1, 0, 0); setup_req(2, 1, 0);
        run_frame(3'b111, 0, -1);
        chk("wd_timeout", timeout, 1'b1);
        chk("wd_ph1_cycles", ph1_cycles, TO);
        chk("wd_saw_ph2", saw_ph2, 1'b1);
        chk("wd_count", pixel_count, 16'd2);

        // Reset in the middle of phase 1
        for (int i = 0; i < 3; i++) setup_req(i, 4, 0);
        cur_pe = 3'b111;
        step(1'b1);
        for (int c = 0; c < 50 && !(m_state == 1 && m_k == 1); c++) step(1'b0);
        chk("rst_reached_ph1", active_phase, 2'd1);
        drive(1'b0);
        req_valid = 3'b111;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_plot", plot, 1'b0);
        chk("rst_count", pixel_count, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin n_pix[i] = 0; ptr[i] = 0; end
        @(posedge clk); #1;
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 3; i++) setup_req(i, 2, 0);
        run_frame(3'b111, 0, -1);
        chk("post_rst_count", pixel_count, 16'd6);

        // Randomised frames
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < 3; i++) setup_req(i, $urandom_range(5), 1);
            vprob = 30 + $urandom_range(70);
            run_frame(3'($urandom_range(7)), 20, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_plot_scheduler.md
Name: vga_plot_scheduler

Overview:
- Sequences and shares the single VGA adapter pixel-write port (plot/x/y/colour) between the per-frame draw sources: background reset, note-block drawer, and scanner/overlay.
- On each frame_start it grants sources one at a time in fixed phase order, so a frame is always cleared before blocks are drawn and blocks are drawn before the overlay.
- Sits between the state handlers and vga_adapter, replacing the ad-hoc combinational colour/x/y mux in the top level.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 = background, 1 = note blocks, 2 = overlay.
- COORD_BITS, 8, width of x and y.
- COLOUR_BITS, 24, colour width (8 bits per channel).
- MAX_X, 159, largest legal x.
- MAX_Y, 119, largest legal y.
- TIMEOUT_CYCLES, 65535, idle cycles allowed within a phase before it is aborted; 0 disables the watchdog.

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous, active-high reset. The port keeps the codebase name; polarity is high.
- frame_start  in  1  one-cycle pulse that begins a frame sequence.
- phase_enable  in  NUM_REQ  per-requester enable; sampled only when frame_start is accepted.
- req_valid  in  NUM_REQ  requester has a pixel.
- req_x  in  NUM_REQ*COORD_BITS  packed x; requester i occupies bits [i*COORD_BITS +: COORD_BITS].
- req_y  in  NUM_REQ*COORD_BITS  packed y, same packing as req_x.
- req_colour  in  NUM_REQ*COLOUR_BITS  packed colour.
- req_last  in  NUM_REQ  current pixel is the requester's final pixel for this frame.
- req_ready  out  NUM_REQ  grant; at most one bit set at any time.
- plot  out  1  write enable to vga_adapter.
- x  out  COORD_BITS  pixel x.
- y  out  COORD_BITS  pixel y.
- colour  out  COLOUR_BITS  pixel colour.
- busy  out  1  high whenever the state is not IDLE.
- active_phase  out  2  index of the phase currently granted.
- frame_done  out  1  one-cycle pulse at the end of a frame.
- pixel_count  out  16  pixels plotted in the current/last frame.
- overrun  out  1  sticky; set by a frame_start that arrives while busy.
- timeout  out  1  sticky; set when a phase is aborted by the watchdog.

Behaviour:
- Reset (asynchronous, any time, including mid-phase):
  - State goes to IDLE.
  - All outputs go to 0: req_ready, plot, x, y, colour, busy, active_phase, frame_done, pixel_count, overrun, timeout.
- States: IDLE, PHASE, DONE.
- IDLE:
  - req_ready = 0.
  - On frame_start: latch phase_enable, clear pixel_count, overrun and timeout.
  - If any latched enable bit is set, go to PHASE with active_phase = lowest enabled index.
  - If no bit is set, go to DONE.
- PHASE k:
  - req_ready[k] = 1 combinationally; all other ready bits are 0.
  - A transfer occurs on any cycle where req_valid[k] & req_ready[k].
- Output pipeline (1 cycle after a transfer):
  - plot = 1, with x/y/colour registered from requester k; pixel_count increments, saturating at 16'hFFFF.
  - A pixel with x > MAX_X or y > MAX_Y is still accepted but clipped: plot = 0 and pixel_count is unchanged.
  - On cycles with no transfer, plot = 0 and x/y/colour hold their last values.
- Phase advance:
  - A transfer with req_last[k] = 1 ends phase k.
  - The next state is PHASE at the next enabled index greater than k, or DONE if none remains.
  - The first pixel of the next phase can transfer on the cycle immediately after the last pixel of the previous phase (no bubble beyond the state register).
- Watchdog:
  - Counts cycles in PHASE without a transfer; reset to 0 on each transfer and on each phase entry.
  - When the count reaches TIMEOUT_CYCLES (nonzero), set timeout and advance exactly as if req_last had been seen.
- DONE: frame_done = 1 for one cycle, req_ready = 0, then go to IDLE.
- A frame_start while busy is ignored and sets overrun.
- A frame_start in the same cycle that DONE returns to IDLE is treated as arriving while busy, so it is ignored.
- req_valid with req_ready low has no effect; requesters must hold their data until ready is seen.

Decomposition:
- Add to DefineMacros.vh:
  - Phase indices: `PHASE_BACKGROUND 0, `PHASE_NOTEBLOCKS 1, `PHASE_OVERLAY 2.
  - Screen bounds: `SCREEN_MAX_X 159, `SCREEN_MAX_Y 119.
  - Colour width: `COLOUR_BITS 24.
- One sub-module, plot_phase_watchdog: counter with clear, enable and terminal-count pulse, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Basic sequencing:
  - Stimulus: phase_enable = 3'b111; each requester sends 2 pixels, the second with req_last.
  - Response: plots in order background, blocks, overlay; pixel_count = 6; frame_done pulses once; exactly one req_ready bit high throughout.
- Skipped phase:
  - Stimulus: phase_enable = 3'b101; requester 1 holds req_valid high.
  - Response: req_ready[1] never asserts; active_phase goes 0 then 2; pixel_count = 4.
- Clipping:
  - Stimulus: requester 0 sends (160,10) then (159,119, last).
  - Response: first pixel gives plot = 0, second gives plot = 1 with x = 159, y = 119; pixel_count = 1.
- Overrun:
  - Stimulus: frame_start pulsed while busy during phase 1.
  - Response: overrun = 1; the sequence continues unchanged; a later frame_start in IDLE clears overrun.
- Watchdog timeout:
  - Stimulus: TIMEOUT_CYCLES = 8; requester 1 never asserts valid.
  - Response: after 8 idle cycles, timeout = 1 and active_phase advances to 2.
- Reset mid-phase:
  - Stimulus: assert resetn during phase 1 with req_valid high.
  - Response: in the same cycle, busy = 0, req_ready = 0, plot = 0; state is IDLE after release.
